lcd_si_serializer: RTL and testbench
====================================

// Module: lcd_si_serializer
// PURPOSE
//  Serial transmit end of the LCD command/data path. Takes the byte, A0 and LED
//  values from the LCD control block and shifts them MSB-first to the LCD panel
//  on SI/SCL with CS framing.
//  Returns the 4-bit phase count (0..15) that the control block uses to pace
//  its data updates and state changes.
// PARAMETERS
//  CLK_DIV   4   clock cycles per SCL half-period (phase tick); legal >= 1
//  IDLE_SCL  1   SCL level while idle / CS deasserted
// PORTS
//  clock        in   1  system clock, rising edge
//  reset_n      in   1  asynchronous, active-low reset
//  si_conv      in   1  level request: byte on data_stream is to be transmitted
//  data_stream  in   8  byte to send, sampled at byte load
//  a0           in   1  command(0)/data(1) flag, sampled with data_stream
//  led_a        in   1  backlight enable, passed through (registered)
//  count        out  4  phase counter, 0..15, 2 phases per bit
//  busy         out  1  1 from byte load until the frame ends
//  lcd_cs_n     out  1  panel chip select, active low
//  lcd_scl      out  1  serial clock; panel samples SI on rising edge
//  lcd_si       out  1  serial data
//  lcd_a0       out  1  registered A0, stable for whole byte
//  lcd_led_a    out  1  registered led_a
// BEHAVIOUR
//  Reset (async, any time incl. mid-byte): count=0, busy=0, lcd_cs_n=1,
//   lcd_scl=IDLE_SCL, lcd_si=0, lcd_a0=0, lcd_led_a=0, shift reg=0, tick cnt=0.
//   Frame is aborted with no partial completion.
//  lcd_led_a <= led_a every cycle; it is independent of the FSM.
//  Tick: internal divider, 1-cycle pulse every CLK_DIV clocks while in SHIFT.
//   The divider restarts at 0 on each byte load.
//  FSM states IDLE, SHIFT, GAP (GAP exists only with LCD_CS_TOGGLE_EN).
//  IDLE: cs_n=1, busy=0, count=0. If si_conv=1, next cycle is the load:
//   shreg<=data_stream, lcd_a0<=a0, cs_n<=0, busy<=1, lcd_scl<=0,
//   lcd_si<=data_stream[7], go to SHIFT. Latency is 1 clock from si_conv to cs_n low.
//  SHIFT, on each tick: count<=count+1 (4-bit).
//   count going odd: lcd_scl<=1 (the rising edge where the panel samples).
//   count going even: lcd_scl<=0, shreg<<=1, lcd_si<=new shreg[7].
//   Bit k (7..0) is held on SI for count 2(7-k) and 2(7-k)+1.
//  End of byte, at the tick while count==15:
//   si_conv=1 means back-to-back: count wraps to 0, reload shreg/lcd_a0 from inputs,
//    lcd_scl<=0, cs_n stays 0. Inputs are sampled at that tick.
//   si_conv=0 means frame end: cs_n<=1, lcd_scl<=IDLE_SCL, busy<=0, count<=0, go to IDLE.
//  si_conv falling mid-byte: the byte always completes; there is no abort path.
//  data_stream/a0 changes mid-byte are ignored; they are sampled only at load.
//  count holds between ticks. Per byte: 16*CLK_DIV cycles.
// CONFIGURATION
//  LCD_CS_TOGGLE_EN defined:
//   at the end of byte with si_conv=1, enter GAP. In GAP: cs_n=1,
//   lcd_scl=IDLE_SCL and count holds at 15 for one tick.
//   Then load as from IDLE: count=0, cs_n=0.
//   busy stays 1 through GAP.
//  Not defined: no GAP state; CS stays low across back-to-back bytes.
// TESTING
//  1 Reset: reset_n=0 mid-SHIFT at count=7 -> same cycle cs_n=1, scl=IDLE_SCL,
//    count=0, busy=0. Release -> IDLE; no SCL edges until si_conv=1.
//  2 Single byte: CLK_DIV=4, data=8'hA5, a0=1, si_conv high 1 cycle ->
//    cs_n low after 1 clk. 8 SCL rises carry SI bits 1,0,1,0,0,1,0,1, with a0=1
//    throughout. cs_n high after 64+1 clks. count steps 0..15 every 4 clks.
//  3 Back-to-back: si_conv held high with data 8'h3C then 8'hFF (updated at
//    count==0) -> 16 SCL rises, cs_n continuously low (toggle off),
//    SI = 00111100 11111111.
//  4 Same stimulus with LCD_CS_TOGGLE_EN -> cs_n high for exactly
//    CLK_DIV clks between bytes, count holds at 15 meanwhile.
//  5 Early drop: si_conv falls at count=3, data_stream changes to 8'h00 at
//    count=5 -> original byte fully sent, frame ends after count 15.
//  6 CLK_DIV=1, data=8'h81, a0=0 -> SCL toggles every clk, byte takes
//    16 clks, lcd_a0=0; led_a toggling is followed on lcd_led_a with 1-clk delay.

Source files
------------

// File: rtl/lcd_si_serializer.sv
// lcd_si_serializer: shifts a byte plus A0 to the LCD panel, MSB first,
// on lcd_si/lcd_scl with lcd_cs_n framing. It also returns the 4-bit phase
// count that the control block uses to pace its updates.
// Optional feature macro: LCD_CS_TOGGLE_EN. When it is defined, chip select
// is released for one phase tick between back-to-back bytes.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no frame, cs_n high, waiting for si_conv
// SHIFT | byte in flight, one phase per tick, 16 phases per byte
// GAP   | cs_n high for one tick between bytes (LCD_CS_TOGGLE_EN only)
module lcd_si_serializer #(
  parameter int   CLK_DIV  = 4,
  parameter logic IDLE_SCL = 1'b1
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       si_conv,
  input  logic [7:0] data_stream,
  input  logic       a0,
  input  logic       led_a,
  output logic [3:0] count,
  output logic       busy,
  output logic       lcd_cs_n,
  output logic       lcd_scl,
  output logic       lcd_si,
  output logic       lcd_a0,
  output logic       lcd_led_a
);

  localparam int TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t          state, state_d;
  logic [TW-1:0]   tick_cnt, tick_cnt_d;
  logic [7:0]      shreg, shreg_d;
  logic [3:0]      count_d;
  logic            busy_d, cs_n_d, scl_d, si_d, a0_d;
  logic            tick, load;

  // The divider idles at zero, so the first tick of a byte lands CLK_DIV
  // clocks after the load.
  assign tick = (state != ST_IDLE) && (tick_cnt == TICK_LAST);

  // Next-state and next-output decode; a load overrides everything else.
  always_comb begin
    state_d    = state;
    tick_cnt_d = tick_cnt;
    shreg_d    = shreg;
    count_d    = count;
    busy_d     = busy;
    cs_n_d     = lcd_cs_n;
    scl_d      = lcd_scl;
    si_d       = lcd_si;
    a0_d       = lcd_a0;
    load       = 1'b0;

    case (state)
      ST_IDLE: begin
        count_d    = 4'd0;
        tick_cnt_d = '0;
        if (si_conv) load = 1'b1;
      end

      ST_SHIFT: begin
        tick_cnt_d = tick ? '0 : tick_cnt + TW'(1);
        if (tick) begin
          if (count == 4'd15) begin
            if (si_conv) begin
`ifdef LCD_CS_TOGGLE_EN
              state_d = ST_GAP;
              cs_n_d  = 1'b1;
              scl_d   = IDLE_SCL;
`else
              load = 1'b1;
`endif
            end else begin
              state_d = ST_IDLE;
              cs_n_d  = 1'b1;
              scl_d   = IDLE_SCL;
              busy_d  = 1'b0;
              count_d = 4'd0;
            end
          end else begin
            count_d = count + 4'd1;
            if (!count[0]) begin
              // Entering an odd phase: rising SCL, panel samples SI here.
              scl_d = 1'b1;
            end else begin
              scl_d   = 1'b0;
              shreg_d = {shreg[6:0], 1'b0};
              si_d    = shreg[6];
            end
          end
        end
      end

      ST_GAP: begin
        // count holds at 15 while cs_n is released for one tick.
        tick_cnt_d = tick ? '0 : tick_cnt + TW'(1);
        if (tick) load = 1'b1;
      end

      default: state_d = ST_IDLE;
    endcase

    if (load) begin
      state_d    = ST_SHIFT;
      tick_cnt_d = '0;
      count_d    = 4'd0;
      shreg_d    = data_stream;
      a0_d       = a0;
      cs_n_d     = 1'b0;
      busy_d     = 1'b1;
      scl_d      = 1'b0;
      si_d       = data_stream[7];
    end
  end

  // FSM state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_d;
  end

  // Datapath and panel-facing output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt <= '0;
      shreg    <= 8'd0;
      count    <= 4'd0;
      busy     <= 1'b0;
      lcd_cs_n <= 1'b1;
      lcd_scl  <= IDLE_SCL;
      lcd_si   <= 1'b0;
      lcd_a0   <= 1'b0;
    end else begin
      tick_cnt <= tick_cnt_d;
      shreg    <= shreg_d;
      count    <= count_d;
      busy     <= busy_d;
      lcd_cs_n <= cs_n_d;
      lcd_scl  <= scl_d;
      lcd_si   <= si_d;
      lcd_a0   <= a0_d;
    end
  end

  // Backlight enable is a plain registered pass-through.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) lcd_led_a <= 1'b0;
    else          lcd_led_a <= led_a;
  end

endmodule

// File: tb/tb_lcd_si_serializer.sv
// tb_lcd_si_serializer: randomized frames on a CLK_DIV=4 instance checked by
// a scoreboard, plus a directed byte on a CLK_DIV=1 instance.
module tb_lcd_si_serializer;

  localparam int CD = 4;
`ifdef LCD_CS_TOGGLE_EN
  localparam int GAP_CYC = CD;
`else
  localparam int GAP_CYC = 0;
`endif
  localparam int BYTE_CYC = 16 * CD;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       si_conv, a0, led_a;
  logic [7:0] data_stream;
  logic [3:0] count;
  logic       busy, lcd_cs_n, lcd_scl, lcd_si, lcd_a0, lcd_led_a;

  logic       conv1, a0_1, led1;
  logic [7:0] data1;
  logic [3:0] count1;
  logic       busy1, cs1, scl1, si1, a0q1, ledq1;

  lcd_si_serializer #(.CLK_DIV(CD), .IDLE_SCL(1'b1)) dut (
    .clock(clock), .reset_n(reset_n), .si_conv(si_conv),
    .data_stream(data_stream), .a0(a0), .led_a(led_a),
    .count(count), .busy(busy), .lcd_cs_n(lcd_cs_n), .lcd_scl(lcd_scl),
    .lcd_si(lcd_si), .lcd_a0(lcd_a0), .lcd_led_a(lcd_led_a)
  );

  lcd_si_serializer #(.CLK_DIV(1), .IDLE_SCL(1'b1)) dut1 (
    .clock(clock), .reset_n(reset_n), .si_conv(conv1),
    .data_stream(data1), .a0(a0_1), .led_a(led1),
    .count(count1), .busy(busy1), .lcd_cs_n(cs1), .lcd_scl(scl1),
    .lcd_si(si1), .lcd_a0(a0q1), .lcd_led_a(ledq1)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic       si;
    logic       a0;
    logic [3:0] cnt;
  } bit_exp_t;

  typedef struct packed {
    int   len;
    logic busy;
  } frm_exp_t;

  bit_exp_t exp_q[$];
  frm_exp_t frm_q[$];
  int vectors = 0;
  int miscompares = 0;
  logic [7:0] fb[8];
  logic       fa[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: bit j (MSB first) is sampled at the SCL rise of phase 2j+1.
  task automatic push_byte(input logic [7:0] b, input logic a);
    for (int j = 0; j < 8; j++) begin
      bit_exp_t e;
      e.si  = b[7-j];
      e.a0  = a;
      e.cnt = 4'(2 * j + 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic push_frame(input int n);
    frm_exp_t f;
`ifdef LCD_CS_TOGGLE_EN
    for (int i = 0; i < n; i++) begin
      f.len  = BYTE_CYC;
      f.busy = (i != n - 1);
      frm_q.push_back(f);
    end
`else
    f.len  = n * BYTE_CYC;
    f.busy = 1'b0;
    frm_q.push_back(f);
`endif
  endtask

  // Sends fb[0..n-1]; drop < 0 picks a random point in the last byte to
  // release si_conv, and data/a0 are scrambled afterwards.
  task automatic send_frame(input int n, input int drop);
    int d;
    @(negedge clock);
    si_conv = 1'b1; data_stream = fb[0]; a0 = fa[0];
    push_byte(fb[0], fa[0]);
    push_frame(n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      @(negedge clock);
      if (i < n - 1) begin
        data_stream = fb[i+1]; a0 = fa[i+1];
        push_byte(fb[i+1], fa[i+1]);
        repeat (BYTE_CYC + GAP_CYC - 1) @(posedge clock);
      end else begin
        d = (drop < 0) ? int'($urandom_range(0, BYTE_CYC - 2)) : drop;
        repeat (d) @(negedge clock);
        si_conv = 1'b0;
        data_stream = 8'($urandom);
        a0 = 1'($urandom);
        repeat (2) @(negedge clock);
        data_stream = 8'h00;
      end
    end
    for (int k = 0; k < 2 * BYTE_CYC && busy; k++) @(negedge clock);
    chk("frame_end_timeout", {31'd0, busy}, 32'd0);
  endtask

  // Scoreboard monitor on the CLK_DIV=4 instance.
  logic prev_scl, prev_cs;
  int   low_len;
  always @(negedge clock) begin
    if (!reset_n) begin
      exp_q.delete();
      frm_q.delete();
      prev_scl = 1'b1;
      prev_cs  = 1'b1;
      low_len  = 0;
    end else begin
      if (lcd_scl && !prev_scl) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_scl_rise", 32'd1, 32'd0);
        end else begin
          bit_exp_t e;
          e = exp_q.pop_front();
          chk("si_at_rise", {31'd0, lcd_si}, {31'd0, e.si});
          chk("a0_at_rise", {31'd0, lcd_a0}, {31'd0, e.a0});
          chk("count_at_rise", {28'd0, count}, {28'd0, e.cnt});
          chk("cs_at_rise", {31'd0, lcd_cs_n}, 32'd0);
        end
      end
      if (!lcd_cs_n) low_len++;
      if (lcd_cs_n && !prev_cs) begin
        if (frm_q.size() == 0) begin
          chk("unexpected_cs_release", 32'd1, 32'd0);
        end else begin
          frm_exp_t f;
          f = frm_q.pop_front();
          chk("cs_low_len", low_len, f.len);
          chk("busy_at_cs_release", {31'd0, busy}, {31'd0, f.busy});
        end
        low_len = 0;
      end
      if (lcd_cs_n && busy)  chk("gap_count", {28'd0, count}, 32'd15);
      if (lcd_cs_n && !busy) chk("idle_scl", {31'd0, lcd_scl}, 32'd1);
      prev_scl = lcd_scl;
      prev_cs  = lcd_cs_n;
    end
  end

  // Backlight pass-through on the CLK_DIV=4 instance: one clock of delay.
  logic led_ok = 1'b0;
  always @(negedge clock) begin
    if (!reset_n) begin
      led_ok = 1'b0;
    end else begin
      if (led_ok) chk("led_follow", {31'd0, lcd_led_a}, {31'd0, led_a});
      led_a  = 1'($urandom);
      led_ok = 1'b1;
    end
  end

  initial begin
    logic [7:0] pat;
    int n;
    reset_n = 1'b0;
    si_conv = 1'b0; data_stream = 8'h00; a0 = 1'b0; led_a = 1'b0;
    conv1 = 1'b0; data1 = 8'h00; a0_1 = 1'b0; led1 = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    chk("rst_cs", {31'd0, lcd_cs_n}, 32'd1);
    chk("rst_scl", {31'd0, lcd_scl}, 32'd1);
    chk("rst_count", {28'd0, count}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_si", {31'd0, lcd_si}, 32'd0);
    chk("rst_a0", {31'd0, lcd_a0}, 32'd0);
    chk("rst_led", {31'd0, lcd_led_a}, 32'd0);
    @(negedge clock);
    #1 reset_n = 1'b1;
    repeat (3) @(negedge clock);

    fb[0] = 8'hA5; fa[0] = 1'b1;
    send_frame(1, 0);
    fb[0] = 8'h3C; fa[0] = 1'b0; fb[1] = 8'hFF; fa[1] = 1'b1;
    send_frame(2, -1);
    fb[0] = 8'h5A; fa[0] = 1'b1;
    send_frame(1, 3 * CD);

    for (int f = 0; f < 12; f++) begin
      n = int'($urandom_range(1, 4));
      for (int i = 0; i < n; i++) begin
        fb[i] = 8'($urandom);
        fa[i] = 1'($urandom);
      end
      send_frame(n, -1);
      repeat ($urandom_range(0, 5)) @(negedge clock);
    end

    // Asynchronous reset in the middle of a byte, at phase 7.
    @(negedge clock);
    pat = 8'($urandom);
    si_conv = 1'b1; data_stream = pat; a0 = 1'b1;
    push_byte(pat, 1'b1);
    push_frame(1);
    @(posedge clock);
    @(negedge clock);
    si_conv = 1'b0;
    for (int k = 0; k < BYTE_CYC && count != 4'd7; k++) @(negedge clock);
    chk("reach_count7", {28'd0, count}, 32'd7);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_cs", {31'd0, lcd_cs_n}, 32'd1);
    chk("midrst_scl", {31'd0, lcd_scl}, 32'd1);
    chk("midrst_count", {28'd0, count}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    @(negedge clock);
    #1 reset_n = 1'b1;
    repeat (12) @(negedge clock);
    chk("post_rst_idle_busy", {31'd0, busy}, 32'd0);

    // CLK_DIV=1 instance: one phase per clock, 16 clocks per byte.
    pat = 8'h81;
    @(negedge clock);
    conv1 = 1'b1; data1 = pat; a0_1 = 1'b0;
    @(posedge clock);
    for (int c = 0; c <= 16; c++) begin
      @(negedge clock);
      if (c == 0) begin
        conv1 = 1'b0;
        data1 = 8'h00;
      end
      chk("d1_count", {28'd0, count1}, 32'(c % 16));
      chk("d1_led", {31'd0, ledq1}, {31'd0, led1});
      led1 = ~led1;
      if (c < 16) begin
        chk("d1_scl", {31'd0, scl1}, 32'(c % 2));
        chk("d1_si", {31'd0, si1}, {31'd0, pat[7 - c/2]});
        chk("d1_cs", {31'd0, cs1}, 32'd0);
        chk("d1_a0", {31'd0, a0q1}, 32'd0);
      end else begin
        chk("d1_end_cs", {31'd0, cs1}, 32'd1);
        chk("d1_end_busy", {31'd0, busy1}, 32'd0);
        chk("d1_end_scl", {31'd0, scl1}, 32'd1);
      end
    end

    repeat (4) @(negedge clock);
    chk("bits_left", exp_q.size(), 32'd0);
    chk("frames_left", frm_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
